hidden_layer_seq: RTL and testbench

//  Sequencer for the hidden layer. For each of N_HIDDEN neurons it walks all
//  N_INPUT inputs, accumulates input*weight, adds the neuron bias and applies

---
 rtl/nn_pkg.sv | 34 +++
 rtl/hidden_layer_seq_if.sv | 31 +++
 rtl/nn_mac_acc.sv | 56 +++++
 rtl/hidden_layer_seq.sv | 140 ++++++++++++++
 tb/tb_hidden_layer_seq.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared constants, FSM state type and activation helper for the nn sequencers
// Purpose: default layer geometry and arithmetic widths, the sequencer state enum,
//          an address-width helper and the ReLU+saturate activation used by both layers.
// Ports:   none (package).
package nn_pkg;

  localparam int N_INPUT  = 784;
  localparam int N_HIDDEN = 30;
  localparam int DATA_W   = 8;
  localparam int FRAC     = 7;
  localparam int ACC_W    = 24;

  // Largest positive activation, 2^(DATA_W-1)-1.
  localparam int OUT_MAX  = (1 << (DATA_W - 1)) - 1;

  typedef enum logic [2:0] {IDLE, MAC, BIAS, OUT, DONE} state_t;

  // Index width for a table of n entries; never below one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Negative sums become 0; positive sums are rescaled by >>>FRAC and clamped.
  function automatic logic [DATA_W-1:0] relu_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shifted;
    shifted = acc >>> FRAC;
    if (acc < 0)
      return '0;
    if (shifted > ACC_W'(OUT_MAX))
      return DATA_W'(OUT_MAX);
    return shifted[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/hidden_layer_seq_if.sv
// rtl/hidden_layer_seq_if.sv - activation stream between the hidden layer and its consumer
// Purpose: valid/ready stream carrying one activation and its neuron index per transfer.
// Ports:   out_valid  master->slave  activation available
//          out_ready  slave->master  consumer accepts when out_valid && out_ready
//          out_idx    master->slave  neuron index of out_data
//          out_data   master->slave  activation value
interface hidden_layer_seq_if #(
  parameter int DATA_W = nn_pkg::DATA_W,
  parameter int IDX_W  = 5
);

  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_idx;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid,
    output out_idx,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/nn_mac_acc.sv
// rtl/nn_mac_acc.sv - signed multiply-accumulate register with clear, step and bias controls
// Purpose: holds the neuron accumulator; en adds a*b, add_bias adds bias<<<FRAC,
//          clear zeroes it (clear wins over the others, add_bias over en).
// Ports:   clk, rst_n       clock, asynchronous active-low reset
//          clear            zero the accumulator
//          en               acc += sext(a)*sext(b)
//          add_bias         acc += sext(bias)<<<FRAC
//          a, b, bias       signed operands
//          acc_bias         combinational acc + (bias<<<FRAC), so the caller can
//                           register the activation in the same cycle the bias lands
module nn_mac_acc
  import nn_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     en,
  input  logic                     add_bias,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] bias,
  output logic signed [ACC_W-1:0]  acc_bias
);

  logic signed [ACC_W-1:0]    acc;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W:0]      acc_x;
  logic signed [ACC_W:0]      prod_x;
  logic signed [ACC_W:0]      bias_x;
  logic signed [ACC_W:0]      mac_sum;
  logic signed [ACC_W:0]      bias_sum;

  assign prod     = (2*DATA_W)'(a) * (2*DATA_W)'(b);
  assign acc_x    = (ACC_W+1)'(acc);
  assign prod_x   = (ACC_W+1)'(prod);
  assign bias_x   = (ACC_W+1)'(bias) <<< FRAC;
  // One guard bit: the sum overflowed ACC_W iff the top two bits disagree.
  assign mac_sum  = acc_x + prod_x;
  assign bias_sum = acc_x + bias_x;
  assign acc_bias = bias_sum[ACC_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (add_bias) begin
      assert (bias_sum[ACC_W] == bias_sum[ACC_W-1]);
      acc <= bias_sum[ACC_W-1:0];
    end else if (en) begin
      assert (mac_sum[ACC_W] == mac_sum[ACC_W-1]);
      acc <= mac_sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/hidden_layer_seq.sv
// rtl/hidden_layer_seq.sv - hidden-layer sequencer: MAC over inputs, bias, ReLU+sat, stream out
// Purpose: for each neuron n walks inputs i, accumulates in*w, adds bias, and streams
//          the 8-bit activation with its index; done pulses after the last accept.
// Ports:   clk, rst_n          clock, asynchronous active-low reset
//          start / busy / done pass control and status
//          in_addr, in_data    input buffer index i and its combinational read
//          w_addr, w_data      weight ROM index n*N_INPUT+i and its combinational read
//          bias_idx, bias_data bias ROM select n and its combinational read
//          out_if              activation stream (master side)
module hidden_layer_seq
  import nn_pkg::*;
#(
  parameter  int N_INPUT  = nn_pkg::N_INPUT,
  parameter  int N_HIDDEN = nn_pkg::N_HIDDEN,
  localparam int IN_AW    = addr_w(N_INPUT),
  localparam int W_AW     = addr_w(N_INPUT * N_HIDDEN),
  localparam int IDX_W    = addr_w(N_HIDDEN)
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [IN_AW-1:0]         in_addr,
  output logic [W_AW-1:0]          w_addr,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] w_data,
  output logic [IDX_W-1:0]         bias_idx,
  input  logic signed [DATA_W-1:0] bias_data,
  hidden_layer_seq_if.master       out_if
);

  state_t                  state;
  logic [IN_AW-1:0]        i_q;
  logic [IDX_W-1:0]        n_q;
  logic [W_AW-1:0]         w_base;
  logic [W_AW-1:0]         w_addr_q;
  logic                    out_valid_q;
  logic [IDX_W-1:0]        out_idx_q;
  logic [DATA_W-1:0]       out_data_q;
  logic signed [ACC_W-1:0] acc_bias;
  logic                    last_i;
  logic                    last_n;
  logic                    accept;
  logic                    acc_clear;

  assign last_i    = (i_q == IN_AW'(N_INPUT - 1));
  assign last_n    = (n_q == IDX_W'(N_HIDDEN - 1));
  assign accept    = (state == OUT) && out_if.out_ready;
  // Zero the accumulator on entry to the first neuron and between neurons.
  assign acc_clear = ((state == IDLE) && start) || (accept && !last_n);

  assign in_addr          = i_q;
  assign w_addr           = w_addr_q;
  assign bias_idx         = n_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_idx   = out_idx_q;
  assign out_if.out_data  = out_data_q;

  nn_mac_acc u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (acc_clear),
    .en       (state == MAC),
    .add_bias (state == BIAS),
    .a        (in_data),
    .b        (w_data),
    .bias     (bias_data),
    .acc_bias (acc_bias)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      i_q         <= '0;
      n_q         <= '0;
      w_base      <= '0;
      w_addr_q    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= MAC;
            busy     <= 1'b1;
            i_q      <= '0;
            n_q      <= '0;
            w_base   <= '0;
            w_addr_q <= '0;
          end
        end
        MAC: begin
          if (last_i) begin
            // Park addresses at i=0 of this neuron while bias and output run.
            i_q      <= '0;
            w_addr_q <= w_base;
            state    <= BIAS;
          end else begin
            i_q      <= i_q + IN_AW'(1);
            w_addr_q <= w_addr_q + W_AW'(1);
          end
        end
        BIAS: begin
          out_data_q  <= relu_sat(acc_bias);
          out_idx_q   <= n_q;
          out_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (out_if.out_ready) begin
            out_valid_q <= 1'b0;
            if (last_n) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              n_q      <= n_q + IDX_W'(1);
              w_base   <= w_base + W_AW'(N_INPUT);
              w_addr_q <= w_base + W_AW'(N_INPUT);
              state    <= MAC;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          n_q      <= '0;
          w_base   <= '0;
          w_addr_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hidden_layer_seq.sv
// tb/tb_hidden_layer_seq.sv - directed self-checking bench for hidden_layer_seq
module tb_hidden_layer_seq;

  localparam int NI    = 4;
  localparam int NH    = 30;
  localparam int IN_AW = 2;
  localparam int W_AW  = 7;
  localparam int IDX_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             busy;
  logic             done;
  logic [IN_AW-1:0] in_addr;
  logic [W_AW-1:0]  w_addr;
  logic [IDX_W-1:0] bias_idx;
  logic [7:0]       in_data;
  logic [7:0]       w_data;
  logic [7:0]       bias_data;
  logic [7:0]       rnd_in, rnd_w, rnd_b;
  int               mode;
  int               checks   = 0;
  int               failures = 0;

  hidden_layer_seq_if #(.DATA_W(8), .IDX_W(IDX_W)) hl_if ();

  hidden_layer_seq #(.N_INPUT(NI), .N_HIDDEN(NH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_addr   (in_addr),
    .w_addr    (w_addr),
    .in_data   (in_data),
    .w_data    (w_data),
    .bias_idx  (bias_idx),
    .bias_data (bias_data),
    .out_if    (hl_if)
  );

  always #5 clk = ~clk;

  // Memory models: mode 0 random, 1 basic, 2 bias/relu, 3 saturation.
  always_comb begin
    in_data   = rnd_in;
    w_data    = rnd_w;
    bias_data = rnd_b;
    case (mode)
      1: begin in_data = 8'h01; w_data = 8'h40; bias_data = 8'h00; end
      2: begin
        in_data   = 8'h01;
        w_data    = ((int'(w_addr) / NI) == 12) ? 8'hC0 : 8'h40;
        bias_data = (bias_idx == 5'd7) ? 8'hFF : (bias_idx == 5'd2) ? 8'h91 : 8'h00;
      end
      3: begin in_data = 8'h7F; w_data = 8'h7F; bias_data = 8'h34; end
      default: ;
    endcase
  end

  // Hand-computed activations per neuron.
  function automatic int exp_out(input int m, input int idx);
    if (m == 3) return 127;
    if (m == 2 && idx == 7) return 1;
    if (m == 2 && (idx == 2 || idx == 12)) return 0;
    return 2;
  endfunction

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic run_pass(input int m, input int stall_idx, input bit check_lat);
    int got_n = 0;
    int done_n = 0;
    int lat = 0;
    int stall_left = 10;
    bit seen_valid = 0;
    bit fin = 0;
    logic [26:0] snap = '0;
    logic [26:0] cur;
    mode = m;
    hl_if.out_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
      start = 1'b0;
      hl_if.out_ready = 1'b1;
      if (cyc == 0) check("busy_after_start", busy, 1);
      if (!seen_valid) begin
        lat++;
        if (hl_if.out_valid) begin
          seen_valid = 1;
          if (check_lat) check("first_valid_latency", lat, NI + 2);
        end
      end
      cur = {in_addr, w_addr, bias_idx, hl_if.out_idx, hl_if.out_data};
      if (hl_if.out_valid) begin
        if (int'(hl_if.out_idx) == stall_idx && stall_left > 0) begin
          if (stall_left == 10) begin
            snap = cur;
            check("stall_addrs", {in_addr, w_addr, bias_idx},
                  {2'd0, 7'(stall_idx * NI), 5'(stall_idx)});
          end else begin
            check("stall_hold", cur, snap);
          end
          if (stall_left == 5) start = 1'b1;
          hl_if.out_ready = 1'b0;
          stall_left--;
        end else begin
          check("out_idx", hl_if.out_idx, got_n);
          check("out_data", hl_if.out_data, exp_out(m, got_n));
          got_n++;
        end
      end
      if (done) begin
        done_n++;
        check("busy_low_at_done", busy, 0);
        start = 1'b1;
        fin = 1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_count", done_n, 1);
    check("output_count", got_n, NH);
    check("done_one_cycle", done, 0);
    @(negedge clk);
    check("start_in_done_ignored", busy, 0);
  endtask

  initial begin
    bit reached;
    bit done_bad;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 0;
    hl_if.out_ready = 1'b0;
    rnd_in = '0; rnd_w = '0; rnd_b = '0;

    // 1: reset with random inputs
    for (int k = 0; k < 3; k++) begin
      rnd_in = 8'($urandom); rnd_w = 8'($urandom); rnd_b = 8'($urandom);
      hl_if.out_ready = 1'($urandom);
      start = 1'($urandom);
      @(negedge clk);
    end
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_addr", in_addr, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_bias_idx", bias_idx, 0);
    check("rst_out_valid", hl_if.out_valid, 0);
    check("rst_out_idx", hl_if.out_idx, 0);
    check("rst_out_data", hl_if.out_data, 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // 2: basic pass with latency; 3: bias/relu; 4: saturation; 5: backpressure
    run_pass(1, -1, 1);
    run_pass(2, -1, 0);
    run_pass(3, -1, 0);
    run_pass(1, 5, 0);

    // 6: abort during MAC of neuron 3
    mode = 1;
    hl_if.out_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    reached = 0;
    for (int c = 0; c < 200 && !reached; c++) begin
      if (bias_idx == 5'd3 && in_addr == 2'd1) reached = 1;
      else @(negedge clk);
    end
    check("abort_reached_neuron3", reached, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_w_addr", w_addr, 0);
    check("abort_bias_idx", bias_idx, 0);
    check("abort_out_valid", hl_if.out_valid, 0);
    done_bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) done_bad = 1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done || busy) done_bad = 1;
    end
    check("abort_no_done", done_bad, 0);
    run_pass(1, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
